fifo_flex: RTL

//  Parametrised synchronous FIFO for signed sample streams (audio path, DSP stages).

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 32 +++
 rtl/fifo_flex.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---- fifo_pkg: shared defaults, FWFT mode encoding and width helper ----
// Rev 1.0
`default_nettype none

package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // The count has to represent DEPTH itself, so it needs one bit more than an address.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ---- fifo_mem: DEPTH x DATA_WIDTH register array, sync write / async read ----
// Rev 1.0
`default_nettype none

module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset: storage contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_flex.sv
// ---- fifo_flex: signed-sample FIFO with count, programmable flags, FWFT, sticky errors ----
// Rev 1.0
`default_nettype none

module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         rd,
    input  logic                         wr,
    input  logic signed [DATA_WIDTH-1:0] w_data,
    input  logic                         flush,
    input  logic                         clr_err,
    output logic signed [DATA_WIDTH-1:0] r_data,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic        [ADDR_WIDTH:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam int         CW    = count_width(ADDR_WIDTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [CW-1:0] CNT_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] CNT_AEMPTY = CW'(AEMPTY_THRESH);

    if (!((AEMPTY_THRESH >= 0) && (AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH)))
    begin : g_param_check
        $error("fifo_flex: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [CW-1:0]         count_next;

    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok & ~flush),
        .waddr (w_addr),
        .wdata (w_data),
        .raddr (r_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_addr <= '0;
            r_addr <= '0;
            count  <= '0;
        end else if (flush) begin
            w_addr <= '0;
            r_addr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) w_addr <= w_addr + ADDR_WIDTH'(1);
            if (rd_ok) r_addr <= r_addr + ADDR_WIDTH'(1);
            count <= count_next;
        end
    end

    // A new error in the same cycle as clr_err stays set; flush cycles never flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && wr && !wr_ok)  overflow <= 1'b1;
            else if (clr_err)            overflow <= 1'b0;
            if (!flush && rd && empty)   underflow <= 1'b1;
            else if (clr_err)            underflow <= 1'b0;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign r_data = mem_rdata;
    end else begin : g_std
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_data <= '0;
            end else if (rd_ok && !flush) begin
                r_data <= mem_rdata;
            end
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == CNT_DEPTH);
    assign almost_empty = (count <= CNT_AEMPTY);
    assign almost_full  = (count >= CNT_AFULL);

endmodule

`default_nettype wire
